// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write-port arbiter sharing one fifo input among r producers.
// Each accepted word takes three cycles: select (word registered onto data_w),
// strobe (fifo_clk high together with ack), hold (fifo_clk low again).
// The fifo status is checked only while selecting, so a word is never strobed
// while the fifo reports full. A burst limit of b words per grant keeps any
// one producer from starving the others.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   req       [r]   requester i has a valid word on its data slice
//   data      [r*n] requester i's word on bits [i*n +: n]
//   ack       [r]   one-cycle pulse: requester i's word was written
//   gnt       [r]   one-hot current owner, zero when idle
//   data_w    [n]   word presented to the fifo data input
//   fifo_clk        registered write strobe to the fifo clock input
//   status    [4]   fifo status, 4'b1111 means full
module fifo_wr_arb #(
    parameter int unsigned n = 8,
    parameter int unsigned r = 4,
    parameter int unsigned b = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [r-1:0]     req,
    input  logic [r*n-1:0]   data,
    output logic [r-1:0]     ack,
    output logic [r-1:0]     gnt,
    output logic [n-1:0]     data_w,
    output logic             fifo_clk,
    input  logic [3:0]       status
);

    localparam int unsigned PW = (r > 1) ? $clog2(r) : 1;
    localparam int unsigned CW = $clog2(b + 1);

    typedef enum logic [1:0] {SEL, WR, HOLD} state_t;

    state_t          state;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   cnt;

    logic            owner_req;
    logic            owner_gnt;
    logic            keep_owner;
    logic            found_hi;
    logic            found_lo;
    logic [PW-1:0]   hi_idx;
    logic [PW-1:0]   lo_idx;
    logic [PW-1:0]   win_idx;
    logic [r-1:0]    win_onehot;
    logic [n-1:0]    win_data;
    logic            fifo_full;

    assign fifo_full = (status == 4'b1111);

    // Winner selection: keep the owner while its burst lasts, otherwise the
    // first request above the owner index wins, wrapping to the lowest index
    // at or below it (circular scan owner+1 .. owner+r).
    always_comb begin
        owner_req  = 1'b0;
        owner_gnt  = 1'b0;
        found_hi   = 1'b0;
        found_lo   = 1'b0;
        hi_idx     = '0;
        lo_idx     = '0;
        win_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < int'(r); i++) begin
            if (PW'(i) == owner) begin
                owner_req = req[i];
                owner_gnt = gnt[i];
            end
            if (req[i] && !found_hi && (PW'(i) > owner)) begin
                found_hi = 1'b1;
                hi_idx   = PW'(i);
            end
            if (req[i] && !found_lo && (PW'(i) <= owner)) begin
                found_lo = 1'b1;
                lo_idx   = PW'(i);
            end
        end
        keep_owner = owner_req && owner_gnt && (cnt < CW'(b));
        if (keep_owner) begin
            win_idx = owner;
        end else if (found_hi) begin
            win_idx = hi_idx;
        end else begin
            win_idx = lo_idx;
        end
        for (int i = 0; i < int'(r); i++) begin
            if (PW'(i) == win_idx) begin
                win_onehot[i] = 1'b1;
                win_data      = data[i*n +: n];
            end
        end
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEL;
            ack      <= '0;
            gnt      <= '0;
            data_w   <= '0;
            fifo_clk <= 1'b0;
            cnt      <= '0;
            owner    <= PW'(r - 1);
        end else begin
            case (state)
                SEL: begin
                    if (fifo_full || (req == '0)) begin
                        gnt <= '0;
                        cnt <= '0;
                    end else begin
                        data_w <= win_data;
                        gnt    <= win_onehot;
                        owner  <= win_idx;
                        // A fresh grant (including a re-grant after the burst
                        // limit) restarts the burst at one word.
                        cnt    <= keep_owner ? CW'(cnt + CW'(1)) : CW'(1);
                        state  <= WR;
                    end
                end
                WR: begin
                    // data_w has been stable for a full cycle before this rise.
                    fifo_clk <= 1'b1;
                    ack      <= gnt;
                    state    <= HOLD;
                end
                HOLD: begin
                    fifo_clk <= 1'b0;
                    ack      <= '0;
                    state    <= SEL;
                end
                default: begin
                    state <= SEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb: scoreboard of expected (requester, word) writes,
// popped on every fifo_clk high cycle. Two instances: r=4/b=4 and r=3/b=1.
module tb_fifo_wr_arb;

    localparam int unsigned N  = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned B  = 4;
    localparam int unsigned R3 = 3;
    localparam int unsigned B3 = 1;

    typedef struct {
        int           who;
        logic [N-1:0] word;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            clr;
    logic [R-1:0]    req;
    logic [R*N-1:0]  data;
    logic [R-1:0]    ack;
    logic [R-1:0]    gnt;
    logic [N-1:0]    data_w;
    logic            fifo_clk;
    logic [3:0]      status;

    logic [R3-1:0]   req3;
    logic [R3*N-1:0] data3;
    logic [R3-1:0]   ack3;
    logic [R3-1:0]   gnt3;
    logic [N-1:0]    data_w3;
    logic            fifo_clk3;
    logic [3:0]      status3;

    int seq  [R];
    int seq3 [R3];

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fifo_wr_arb #(.n(N), .r(R), .b(B)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .gnt(gnt),
        .data_w(data_w), .fifo_clk(fifo_clk), .status(status)
    );

    fifo_wr_arb #(.n(N), .r(R3), .b(B3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .data(data3), .ack(ack3), .gnt(gnt3),
        .data_w(data_w3), .fifo_clk(fifo_clk3), .status(status3)
    );

    // Producers: requester i offers word {i, seq[i]} and advances after its ack.
    always @(negedge clk) begin
        for (int i = 0; i < int'(R); i++) begin
            if (clr) seq[i] <= 0;
            else if (ack[i]) seq[i] <= seq[i] + 1;
        end
        for (int i = 0; i < int'(R3); i++) begin
            if (clr) seq3[i] <= 0;
            else if (ack3[i]) seq3[i] <= seq3[i] + 1;
        end
    end

    always_comb begin
        data  = '0;
        data3 = '0;
        for (int i = 0; i < int'(R); i++) data[i*N +: N] = {4'(i), 4'(seq[i])};
        for (int i = 0; i < int'(R3); i++) data3[i*N +: N] = {4'(i), 4'(seq3[i])};
    end

    function automatic logic [N-1:0] mkw(input int who, input int k);
        return {4'(who), 4'(k)};
    endfunction

    function automatic exp_t mke(input int who, input int k);
        exp_t e;
        e.who  = who;
        e.word = mkw(who, k);
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b1;
        req = '0;
        req3 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle(input int c);
        req  = '0;
        req3 = '0;
        repeat (c) @(negedge clk);
    endtask

    task automatic test_reset();
        req    = 4'b1111;
        status = 4'b0000;
        rst    = 1'b1;
        clr    = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (ack !== '0)      begin n_err++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        if (gnt !== '0)      begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        if (data_w !== '0)   begin n_err++; $display("FAIL reset_data_w got=%h exp=00", data_w); end
        if (fifo_clk !== 1'b0) begin n_err++; $display("FAIL reset_fifo_clk got=%b exp=0", fifo_clk); end
        rst = 1'b0;
        clr = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        exp_t e;
        logic [R-1:0] ea;
        int last, nseen;
        bit started;
        do_reset();
        status = 4'b0001;
        q.delete();
        for (int k = 0; k < 6; k++) q.push_back(mke(2, k));
        req = 4'b0100;
        last = -1; nseen = 0; started = 0;
        for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (gnt != '0) started = 1;
            if (started) begin
                n_cmp++;
                if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", cyc, gnt); end
            end
            if (fifo_clk) begin
                e = q.pop_front();
                ea = 4'(1 << e.who);
                n_cmp++;
                if (data_w !== e.word || ack !== ea) begin
                    n_err++;
                    $display("FAIL single_word cyc=%0d got=%h/%b exp=%h/%b", cyc, data_w, ack, e.word, ea);
                end
                n_cmp++;
                if ((last < 0 && cyc != 1) || (last >= 0 && cyc - last != 3)) begin
                    n_err++;
                    $display("FAIL single_timing cyc=%0d last=%0d exp_gap=3", cyc, last);
                end
                last = cyc;
                nseen++;
                if (nseen == 6) req = '0;
            end else begin
                n_cmp++;
                if (ack !== '0) begin n_err++; $display("FAIL single_ack_idle cyc=%0d got=%b exp=0000", cyc, ack); end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL single_timeout left=%0d exp=0", q.size()); end
        idle(4);
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [R-1:0] ea;
        int cnt_w [R];
        int nseen, who;
        do_reset();
        status = 4'b0010;
        q.delete();
        for (int i = 0; i < int'(R); i++) cnt_w[i] = 0;
        for (int idx = 0; idx < 17; idx++) begin
            who = (idx / 4) % 4;
            q.push_back(mke(who, cnt_w[who]));
            cnt_w[who]++;
        end
        req = 4'b1111;
        nseen = 0;
        for (int cyc = 0; cyc < 80 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (fifo_clk) begin
                e = q.pop_front();
                ea = 4'(1 << e.who);
                n_cmp++;
                if (data_w !== e.word || ack !== ea) begin
                    n_err++;
                    $display("FAIL rr_word n=%0d got=%h/%b exp=%h/%b", nseen, data_w, ack, e.word, ea);
                end
                nseen++;
                if (nseen == 17) req = '0;
            end else if (ack !== '0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rr_ack_idle cyc=%0d got=%b exp=0000", cyc, ack);
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL rr_timeout left=%0d exp=0", q.size()); end
        idle(4);
    endtask

    task automatic test_full();
        do_reset();
        status = 4'b1111;
        req = 4'b0010;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (fifo_clk !== 1'b0 || ack !== '0 || gnt !== '0) begin
                n_err++;
                $display("FAIL full_block cyc=%0d got=%b/%b/%b exp=0/0000/0000", cyc, fifo_clk, ack, gnt);
            end
        end
        status = 4'b0111;
        @(negedge clk);
        n_cmp++;
        if (fifo_clk !== 1'b0 || gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL full_release_sel got=%b/%b exp=0/0010", fifo_clk, gnt);
        end
        @(negedge clk);
        n_cmp++;
        if (fifo_clk !== 1'b1 || ack !== 4'b0010 || data_w !== mkw(1, 0)) begin
            n_err++;
            $display("FAIL full_release_strobe got=%b/%b/%h exp=1/0010/%h", fifo_clk, ack, data_w, mkw(1, 0));
        end
        idle(4);
        status = 4'b0000;
    endtask

    task automatic test_drop();
        exp_t e;
        logic [R-1:0] ea;
        int nseen;
        do_reset();
        status = 4'b0000;
        q.delete();
        q.push_back(mke(0, 0));
        q.push_back(mke(0, 1));
        for (int k = 0; k < 4; k++) q.push_back(mke(3, k));
        q.push_back(mke(0, 2));
        req = 4'b1001;
        nseen = 0;
        for (int cyc = 0; cyc < 60 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (fifo_clk) begin
                e = q.pop_front();
                ea = 4'(1 << e.who);
                n_cmp++;
                if (data_w !== e.word || ack !== ea) begin
                    n_err++;
                    $display("FAIL drop_word n=%0d got=%h/%b exp=%h/%b", nseen, data_w, ack, e.word, ea);
                end
                nseen++;
                if (nseen == 2) req = 4'b1000;
                if (nseen == 3) req = 4'b1001;
                if (nseen == 7) req = '0;
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL drop_timeout left=%0d exp=0", q.size()); end
        idle(4);
    endtask

    task automatic test_rst_wr();
        exp_t e;
        logic [R-1:0] ea;
        int nseen;
        bit hit;
        do_reset();
        status = 4'b0000;
        req = 4'b0100;
        hit = 0;
        for (int cyc = 0; cyc < 5 && !hit; cyc++) begin
            @(negedge clk);
            if (gnt != '0) hit = 1;
        end
        n_cmp++;
        if (!hit || fifo_clk !== 1'b0) begin
            n_err++;
            $display("FAIL rstwr_reach_wr got=%0d/%b exp=1/0", hit, fifo_clk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fifo_clk !== 1'b0 || ack !== '0 || gnt !== '0 || data_w !== '0) begin
            n_err++;
            $display("FAIL rstwr_outputs got=%b/%b/%b/%h exp=0/0000/0000/00", fifo_clk, ack, gnt, data_w);
        end
        rst = 1'b0;
        q.delete();
        q.push_back(mke(0, 0));
        q.push_back(mke(2, 0));
        req = 4'b0101;
        nseen = 0;
        for (int cyc = 0; cyc < 30 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (fifo_clk) begin
                e = q.pop_front();
                ea = 4'(1 << e.who);
                n_cmp++;
                if (data_w !== e.word || ack !== ea) begin
                    n_err++;
                    $display("FAIL rstwr_word n=%0d got=%h/%b exp=%h/%b", nseen, data_w, ack, e.word, ea);
                end
                nseen++;
                if (nseen == 1) req = 4'b0100;
                if (nseen == 2) req = '0;
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL rstwr_timeout left=%0d exp=0", q.size()); end
        idle(4);
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [R3-1:0] ea;
        int nseen;
        do_reset();
        status3 = 4'b0000;
        q.delete();
        for (int k = 0; k < 3; k++) begin
            q.push_back(mke(0, k));
            q.push_back(mke(2, k));
        end
        req3 = 3'b101;
        nseen = 0;
        for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (fifo_clk3) begin
                e = q.pop_front();
                ea = 3'(1 << e.who);
                n_cmp++;
                if (data_w3 !== e.word || ack3 !== ea) begin
                    n_err++;
                    $display("FAIL wrap_word n=%0d got=%h/%b exp=%h/%b", nseen, data_w3, ack3, e.word, ea);
                end
                nseen++;
                if (nseen == 6) req3 = '0;
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL wrap_timeout left=%0d exp=0", q.size()); end
        idle(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        clr     = 1'b1;
        req     = '0;
        req3    = '0;
        status  = 4'b0000;
        status3 = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_drop();
        test_rst_wr();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
